// File: rtl/hsv_pkg.sv
// Shared types and constants for the hue calculator.
package hsv_pkg;

  typedef enum logic [1:0] {
    FUNC_NONE = 2'd0,
    FUNC_RED  = 2'd1,
    FUNC_GRN  = 2'd2,
    FUNC_BLU  = 2'd3
  } func_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    FIN  = 2'd2
  } state_e;

  localparam int HUE_SCALE   = 60;
  localparam int HUE_OFS_GRN = 120;
  localparam int HUE_OFS_BLU = 240;
  localparam int HUE_WRAP    = 360;

  // mag*60 without a multiplier: (mag<<6) - (mag<<2); 255*64 still fits 14 bits.
  function automatic logic [13:0] times_scale(input logic [7:0] mag);
    logic [13:0] w_ext;
    w_ext = {6'b0, mag};
    return (w_ext << 6) - (w_ext << 2);
  endfunction

endpackage

// File: rtl/hsv_hue_calc_div.sv
// Unsigned iterative restoring divider, one quotient bit per clock.
// A zero divisor still runs the full step count; the result is just meaningless.
module seq_restoring_div #(
  parameter int N_W = 14,
  parameter int D_W = 8
) (
  input  logic           i_clk,
  input  logic           i_rstn,
  input  logic           i_start,
  input  logic [N_W-1:0] i_num,
  input  logic [D_W-1:0] i_den,
  output logic           o_done,
  output logic [N_W-1:0] o_quo
);

  localparam int CNT_W = $clog2(N_W);

  logic [CNT_W-1:0] r_cnt;
  logic             r_busy;
  logic [N_W-1:0]   r_num;
  logic [D_W-1:0]   r_den;
  logic [D_W-1:0]   r_rem;
  logic [N_W-1:0]   r_quo;

  logic [D_W:0]     w_trial;
  logic [D_W:0]     w_diff;
  logic             w_ge;

  // Trial subtraction of the divisor from the shifted partial remainder.
  always_comb begin
    w_trial = {r_rem, r_num[N_W-1]};
    w_ge    = (w_trial >= {1'b0, r_den});
    w_diff  = w_trial - {1'b0, r_den};
  end

  // Load on start, then one restoring step per cycle until the counter hits zero.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_cnt  <= '0;
      r_busy <= 1'b0;
      r_num  <= '0;
      r_den  <= '0;
      r_rem  <= '0;
      r_quo  <= '0;
    end else if (i_start) begin
      r_cnt  <= CNT_W'(N_W - 1);
      r_busy <= 1'b1;
      r_num  <= i_num;
      r_den  <= i_den;
      r_rem  <= '0;
      r_quo  <= '0;
    end else if (r_busy) begin
      r_num <= {r_num[N_W-2:0], 1'b0};
      r_rem <= w_ge ? w_diff[D_W-1:0] : w_trial[D_W-1:0];
      r_quo <= {r_quo[N_W-2:0], w_ge};
      r_cnt <= r_cnt - 1'b1;
      if (r_cnt == '0) r_busy <= 1'b0;
    end
  end

  // Done flags the edge on which the last step is taken.
  assign o_done = r_busy && (r_cnt == '0);
  assign o_quo  = r_quo;

endmodule

// File: rtl/hsv_hue_calc.sv
// Hue calculator: |dividend|*60 / divisor, then sign, sector offset and wrap.
module hsv_hue_calc
  import hsv_pkg::*;
#(
  parameter int IN_W      = 9,
  parameter int HUE_W     = 9,
  parameter int DIV_STEPS = 14
) (
  input  logic             i_clk,
  input  logic             i_rstn,
  input  logic [IN_W-1:0]  i_dividend,
  input  logic             i_dividend_valid,
  input  logic [IN_W-1:0]  i_divisor,
  input  logic             i_divisor_valid,
  input  logic [1:0]       i_function,
  output logic             o_ready,
  output logic [HUE_W-1:0] o_hue,
  output logic             o_valid,
  output logic             o_err,
  output logic             o_drop
);

  state_e              r_state;
  state_e              w_state_nxt;

  logic [DIV_STEPS-1:0] r_num;
  logic                 r_sign;
  logic [7:0]           r_den;
  func_e                r_func;
  logic                 r_start;
  logic [HUE_W-1:0]     r_hue;
  logic                 r_valid;
  logic                 r_err;
  logic                 r_drop;

  logic                 w_both_valid;
  logic                 w_accept;
  logic                 w_fin;
  logic [IN_W-1:0]      w_neg;
  logic [7:0]           w_mag;
  logic                 w_done;
  logic [DIV_STEPS-1:0] w_quo;
  logic [HUE_W-1:0]     w_q;
  logic [HUE_W-1:0]     w_hue;
  logic                 w_err;
  logic                 w_unused_div_msb;

  // Divisor is max-min of 8-bit channels; its top bit carries no information.
  assign w_unused_div_msb = i_divisor[IN_W-1];

  assign w_both_valid = i_dividend_valid & i_divisor_valid;
  assign w_accept     = w_both_valid & o_ready;
  assign w_neg        = -i_dividend;
  assign w_mag        = i_dividend[IN_W-1] ? w_neg[7:0] : i_dividend[7:0];

  // State register.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) r_state <= IDLE;
    else         r_state <= w_state_nxt;
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_state_nxt = DIV;
      DIV:     if (w_done)   w_state_nxt = FIN;
      FIN:     w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // State-decoded outputs.
  always_comb begin
    o_ready = 1'b0;
    w_fin   = 1'b0;
    case (r_state)
      IDLE:    o_ready = 1'b1;
      FIN:     w_fin   = 1'b1;
      default: ;
    endcase
  end

  seq_restoring_div #(
    .N_W (DIV_STEPS),
    .D_W (8)
  ) u_div (
    .i_clk   (i_clk),
    .i_rstn  (i_rstn),
    .i_start (r_start),
    .i_num   (r_num),
    .i_den   (r_den),
    .o_done  (w_done),
    .o_quo   (w_quo)
  );

  // Quotient is bounded by 60 because |dividend| <= divisor; clamp defends against bad input pairs.
  always_comb begin
    w_q = (w_quo > DIV_STEPS'(HUE_SCALE)) ? HUE_W'(HUE_SCALE) : HUE_W'(w_quo);
  end

  // Apply sign, sector offset and wrap at 360.
  always_comb begin
    w_hue = '0;
    w_err = 1'b0;
    if (r_func != FUNC_NONE) begin
      if (r_den == 8'd0) begin
        w_err = 1'b1;
      end else begin
        case (r_func)
          FUNC_RED: w_hue = (r_sign && (w_q != '0)) ? HUE_W'(HUE_WRAP) - w_q : w_q;
          FUNC_GRN: w_hue = r_sign ? HUE_W'(HUE_OFS_GRN) - w_q : HUE_W'(HUE_OFS_GRN) + w_q;
          FUNC_BLU: w_hue = r_sign ? HUE_W'(HUE_OFS_BLU) - w_q : HUE_W'(HUE_OFS_BLU) + w_q;
          default:  w_hue = '0;
        endcase
      end
    end
  end

  // Operand capture on accept, drop flag, and result registers loaded in FIN.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_num   <= '0;
      r_sign  <= 1'b0;
      r_den   <= '0;
      r_func  <= FUNC_NONE;
      r_start <= 1'b0;
      r_hue   <= '0;
      r_valid <= 1'b0;
      r_err   <= 1'b0;
      r_drop  <= 1'b0;
    end else begin
      r_start <= w_accept;
      r_drop  <= w_both_valid & ~o_ready;
      r_valid <= w_fin;
      if (w_accept) begin
        r_num  <= times_scale(w_mag);
        r_sign <= i_dividend[IN_W-1];
        r_den  <= i_divisor[7:0];
        r_func <= func_e'(i_function);
      end
      if (w_fin) begin
        r_hue <= w_hue;
        r_err <= w_err;
      end
    end
  end

  assign o_hue   = r_hue;
  assign o_valid = r_valid;
  assign o_err   = r_err;
  assign o_drop  = r_drop;

endmodule

// File: tb/tb_hsv_hue_calc.sv
// Directed-vector bench with a result scoreboard for hsv_hue_calc.
module tb_hsv_hue_calc;

  logic       clk = 1'b0;
  logic       rstn;
  logic [8:0] dividend;
  logic       dividend_valid;
  logic [8:0] divisor;
  logic       divisor_valid;
  logic [1:0] func;
  logic       ready;
  logic [8:0] hue;
  logic       valid;
  logic       err;
  logic       drop;

  typedef struct {
    int hue;
    int err;
    int due;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  hsv_hue_calc dut (
    .i_clk            (clk),
    .i_rstn           (rstn),
    .i_dividend       (dividend),
    .i_dividend_valid (dividend_valid),
    .i_divisor        (divisor),
    .i_divisor_valid  (divisor_valid),
    .i_function       (func),
    .o_ready          (ready),
    .o_hue            (hue),
    .o_valid          (valid),
    .o_err            (err),
    .o_drop           (drop)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Monitor: every o_valid pops the oldest expectation and checks value and timing.
  always @(negedge clk) begin
    if (rstn && valid) begin
      if (sb.size() == 0) begin
        chk("unexpected_valid", 32'(valid), 0);
      end else begin
        mon_e = sb.pop_front();
        chk("hue", 32'(hue), mon_e.hue);
        chk("err", 32'(err), mon_e.err);
        chk("latency_cycle", cyc, mon_e.due);
      end
    end
  end

  task automatic send(input int dvd, input int dvs, input int fn, input int exp_hue, input int exp_err);
    int n;
    n = 0;
    @(negedge clk);
    while (!ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!ready) chk("ready_timeout", 32'(ready), 1);
    dividend       = 9'(dvd);
    divisor        = 9'(dvs);
    func           = 2'(fn);
    dividend_valid = 1'b1;
    divisor_valid  = 1'b1;
    sb.push_back('{exp_hue, exp_err, cyc + 1 + 16});
    @(posedge clk);
    #1;
    dividend_valid = 1'b0;
    divisor_valid  = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      chk("drain_timeout", sb.size(), 0);
      sb.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    rstn           = 1'b0;
    dividend       = '0;
    divisor        = '0;
    func           = '0;
    dividend_valid = 1'b0;
    divisor_valid  = 1'b0;
    #23;
    chk("rst_ready", 32'(ready), 1);
    chk("rst_hue", 32'(hue), 0);
    chk("rst_valid", 32'(valid), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_drop", 32'(drop), 0);
    @(negedge clk);
    rstn = 1'b1;

    // Basic case with ready-low window and exact latency.
    send(40, 80, 1, 30, 0);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      chk("busy_ready_low", 32'(ready), 0);
    end
    @(negedge clk);
    chk("ready_with_valid", 32'(ready), 1);
    chk("valid_at_16", 32'(valid), 1);
    drain();

    send(-10, 100, 1, 354, 0);
    send(-255, 255, 1, 300, 0);
    send(255, 255, 1, 60, 0);
    send(-248, 248, 2, 60, 0);
    send(7, 200, 3, 242, 0);
    send(-200, 200, 3, 180, 0);
    drain();
    repeat (5) @(negedge clk);
    chk("hold_hue", 32'(hue), 180);
    chk("hold_err", 32'(err), 0);

    send(0, 0, 0, 0, 0);
    send(0, 0, 2, 0, 1);
    drain();

    // A single qualifier must not start a computation.
    @(negedge clk);
    dividend       = 9'(50);
    divisor        = 9'(100);
    func           = 2'd1;
    dividend_valid = 1'b1;
    @(negedge clk);
    dividend_valid = 1'b0;
    chk("half_valid_ignored", 32'(ready), 1);
    chk("half_valid_no_drop", 32'(drop), 0);

    // Input while busy is dropped; in-flight result is unaffected.
    send(-10, 100, 1, 354, 0);
    repeat (4) @(negedge clk);
    dividend       = 9'(100);
    divisor        = 9'(100);
    func           = 2'd3;
    dividend_valid = 1'b1;
    divisor_valid  = 1'b1;
    @(posedge clk);
    #1;
    dividend_valid = 1'b0;
    divisor_valid  = 1'b0;
    @(negedge clk);
    chk("drop_pulse", 32'(drop), 1);
    @(negedge clk);
    chk("drop_one_cycle", 32'(drop), 0);
    drain();

    // Second input accepted in the o_valid cycle.
    send(7, 200, 3, 242, 0);
    send(-200, 200, 3, 180, 0);
    drain();

    // Reset mid-divide aborts with no result.
    send(255, 255, 2, 180, 0);
    repeat (6) @(negedge clk);
    rstn = 1'b0;
    #1;
    sb.delete();
    chk("midrst_ready", 32'(ready), 1);
    chk("midrst_hue", 32'(hue), 0);
    chk("midrst_valid", 32'(valid), 0);
    @(negedge clk);
    chk("midrst_ready_held", 32'(ready), 1);
    rstn = 1'b1;
    repeat (20) @(negedge clk);
    chk("post_rst_idle_ready", 32'(ready), 1);
    send(40, 80, 1, 30, 0);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
